i2c_txn_arbiter: RTL and testbench

//  Shares one I2C_master instance between NUM_REQ requesters.
//  - Each requester submits one single-byte read or write transaction.
//  - A round-robin arbiter picks one requester, sequences the master's start_txn/busy/done handshake,
//    and returns the read data plus an error status to the granted requester only.
//  - Sits between system-side clients (sensor pollers, config loaders) and the I2C master; drives all

---
 rtl/i2c_txn_arbiter.sv | 250 +++++++++++++++++++++++++
 tb/tb_i2c_txn_arbiter.sv | 348 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_txn_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : i2c_txn_arbiter
// Description : Round-robin arbiter sharing one I2C master between NUM_REQ
//               requesters. Each requester submits one single-byte read or
//               write. The winner's command is latched and driven to the
//               master, and the start/busy/done handshake is sequenced. The
//               read byte and error status go back to the winner only.
// Ports       : clk_400, rst        - clock, async active-high reset
//               req/req_rw/req_addr/req_wdata - per-requester command
//               grant, rsp_valid    - one-hot owner / completion pulse
//               rsp_rdata, rsp_err  - read byte, 00 ok / 01 nack / 10 timeout
//               m_*                 - I2C master command / status
// Revision    : 1.0 - initial release
// ============================================================================
module i2c_txn_arbiter #(
    parameter int NUM_REQ     = 2,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic                 clk_400,
    input  logic                 rst,
    input  logic [NUM_REQ-1:0]   req,
    input  logic [NUM_REQ-1:0]   req_rw,
    input  logic [7*NUM_REQ-1:0] req_addr,
    input  logic [8*NUM_REQ-1:0] req_wdata,
    output logic [NUM_REQ-1:0]   grant,
    output logic [NUM_REQ-1:0]   rsp_valid,
    output logic [7:0]           rsp_rdata,
    output logic [1:0]           rsp_err,
    output logic                 m_start_txn,
    output logic                 m_rw,
    output logic [6:0]           m_sub_addr,
    output logic [7:0]           m_data_in,
    output logic                 m_next_byte,
    input  logic [7:0]           m_data_out,
    input  logic                 m_busy,
    input  logic                 m_done,
    input  logic                 m_ack_error
);

    localparam int c_PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int c_TMR_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

    localparam logic [c_PTR_W-1:0] c_LAST_IDX  = c_PTR_W'(NUM_REQ - 1);
    localparam logic [c_PTR_W:0]   c_NUM_REQ   = (c_PTR_W + 1)'(NUM_REQ);
    localparam logic [c_TMR_W-1:0] c_TMO_LAST  = c_TMR_W'(TIMEOUT_CYC - 1);
    localparam logic [c_TMR_W-1:0] c_TMR_ONE   = c_TMR_W'(1);
    localparam logic [c_PTR_W-1:0] c_PTR_ONE   = c_PTR_W'(1);
    localparam logic [NUM_REQ-1:0] c_GRANT_ONE = NUM_REQ'(1);
    localparam logic [1:0]         c_ERR_OK    = 2'b00;
    localparam logic [1:0]         c_ERR_ACK   = 2'b01;
    localparam logic [1:0]         c_ERR_TMO   = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_ACCEPT = 3'd2,
        S_RUN    = 3'd3,
        S_RESP   = 3'd4
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;

    logic [c_PTR_W-1:0]   r_ptr;
    logic [c_PTR_W-1:0]   r_win;
    logic [NUM_REQ-1:0]   r_grant;
    logic                 r_start;
    logic                 r_rw;
    logic [6:0]           r_addr;
    logic [7:0]           r_wdata;
    logic [c_TMR_W-1:0]   r_timer;
    logic [7:0]           r_rdata;
    logic [1:0]           r_err;

    logic [2*NUM_REQ-1:0] w_req2;
    logic [NUM_REQ-1:0]   w_rot;
    logic [c_PTR_W-1:0]   w_off;
    logic [c_PTR_W:0]     w_sum;
    logic [c_PTR_W-1:0]   w_win;
    logic                 w_sel_rw;
    logic [6:0]           w_sel_addr;
    logic [7:0]           w_sel_wdata;

    logic                 w_launch;
    logic                 w_tmr_clr;
    logic                 w_capture;
    logic                 w_timeout;
    logic                 w_release;

    // ------------------------------------------------------------------
    // Round-robin search: rotate the request vector so rr_ptr sits at bit 0,
    // take the lowest set bit, then map the offset back to an index.
    // ------------------------------------------------------------------
    assign w_req2 = {req, req};
    assign w_rot  = NUM_REQ'(w_req2 >> r_ptr);

    always_comb begin
        w_off = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (w_rot[k]) begin
                w_off = c_PTR_W'(k);
            end
        end
    end

    // Both operands are below NUM_REQ, so one conditional subtract wraps it.
    assign w_sum = {1'b0, r_ptr} + {1'b0, w_off};
    assign w_win = (w_sum >= c_NUM_REQ) ? (w_sum[c_PTR_W-1:0] - c_NUM_REQ[c_PTR_W-1:0])
                                        : w_sum[c_PTR_W-1:0];

    always_comb begin
        w_sel_rw    = 1'b0;
        w_sel_addr  = '0;
        w_sel_wdata = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (w_win == c_PTR_W'(k)) begin
                w_sel_rw    = req_rw[k];
                w_sel_addr  = req_addr[7*k +: 7];
                w_sel_wdata = req_wdata[8*k +: 8];
            end
        end
    end

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk_400 or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_launch    = 1'b0;
        w_tmr_clr   = 1'b0;
        w_capture   = 1'b0;
        w_timeout   = 1'b0;
        w_release   = 1'b0;
        rsp_valid   = '0;
        rsp_rdata   = '0;
        rsp_err     = '0;
        case (r_state)
            S_IDLE: begin
                if (|req) begin
                    w_launch    = 1'b1;
                    w_state_nxt = S_START;
                end
            end
            S_START: begin
                w_tmr_clr   = 1'b1;
                w_state_nxt = S_ACCEPT;
            end
            S_ACCEPT: begin
                // Only busy is watched here: done may still be high from
                // the previous transaction.
                if (m_busy) begin
                    w_tmr_clr   = 1'b1;
                    w_state_nxt = S_RUN;
                end else if (r_timer == c_TMO_LAST) begin
                    w_timeout   = 1'b1;
                    w_state_nxt = S_RESP;
                end
            end
            S_RUN: begin
                if (m_done && !m_busy) begin
                    w_capture   = 1'b1;
                    w_state_nxt = S_RESP;
                end else if (r_timer == c_TMO_LAST) begin
                    w_timeout   = 1'b1;
                    w_state_nxt = S_RESP;
                end
            end
            S_RESP: begin
                rsp_valid   = r_grant;
                rsp_rdata   = r_rdata;
                rsp_err     = r_err;
                w_release   = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk_400 or posedge rst) begin
        if (rst) begin
            r_ptr   <= '0;
            r_win   <= '0;
            r_grant <= '0;
            r_start <= 1'b0;
            r_rw    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_timer <= '0;
            r_rdata <= '0;
            r_err   <= '0;
        end else begin
            // Registered so the pulse lands two cycles after req is sampled.
            r_start <= (r_state == S_START);

            if (w_launch) begin
                r_win   <= w_win;
                r_grant <= c_GRANT_ONE << w_win;
                r_rw    <= w_sel_rw;
                r_addr  <= w_sel_addr;
                r_wdata <= w_sel_wdata;
            end

            if (w_tmr_clr) begin
                r_timer <= '0;
            end else if (r_state == S_ACCEPT || r_state == S_RUN) begin
                r_timer <= r_timer + c_TMR_ONE;
            end

            if (w_capture) begin
                r_err   <= m_ack_error ? c_ERR_ACK : c_ERR_OK;
                // A nacked transfer or a write never returns data.
                r_rdata <= (m_ack_error || !r_rw) ? 8'h00 : m_data_out;
            end else if (w_timeout) begin
                r_err   <= c_ERR_TMO;
                r_rdata <= 8'h00;
            end

            if (w_release) begin
                r_ptr   <= (r_win == c_LAST_IDX) ? '0 : r_win + c_PTR_ONE;
                r_grant <= '0;
                r_rw    <= 1'b0;
                r_addr  <= '0;
                r_wdata <= '0;
            end
        end
    end

    assign grant       = r_grant;
    assign m_start_txn = r_start;
    assign m_rw        = r_rw;
    assign m_sub_addr  = r_addr;
    assign m_data_in   = r_wdata;
    assign m_next_byte = 1'b0;

endmodule
`default_nettype wire

// File: tb/tb_i2c_txn_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_i2c_txn_arbiter
// Description : Self-checking bench for i2c_txn_arbiter. A behavioural I2C
//               master with a small subordinate register file answers the
//               arbiter; a vector table drives single transactions and
//               hand-written sequences cover arbitration order, timeout,
//               dropped requests and reset mid-transaction.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_i2c_txn_arbiter;

    localparam int NUM_REQ     = 2;
    localparam int TIMEOUT_CYC = 64;
    localparam int MST_LAT     = 4;

    logic                 clk_400;
    logic                 rst;
    logic [NUM_REQ-1:0]   req;
    logic [NUM_REQ-1:0]   req_rw;
    logic [7*NUM_REQ-1:0] req_addr;
    logic [8*NUM_REQ-1:0] req_wdata;
    logic [NUM_REQ-1:0]   grant;
    logic [NUM_REQ-1:0]   rsp_valid;
    logic [7:0]           rsp_rdata;
    logic [1:0]           rsp_err;
    logic                 m_start_txn;
    logic                 m_rw;
    logic [6:0]           m_sub_addr;
    logic [7:0]           m_data_in;
    logic                 m_next_byte;
    logic [7:0]           m_data_out;
    logic                 m_busy;
    logic                 m_done;
    logic                 m_ack_error;

    i2c_txn_arbiter #(
        .NUM_REQ     (NUM_REQ),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) dut (
        .clk_400     (clk_400),
        .rst         (rst),
        .req         (req),
        .req_rw      (req_rw),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .grant       (grant),
        .rsp_valid   (rsp_valid),
        .rsp_rdata   (rsp_rdata),
        .rsp_err     (rsp_err),
        .m_start_txn (m_start_txn),
        .m_rw        (m_rw),
        .m_sub_addr  (m_sub_addr),
        .m_data_in   (m_data_in),
        .m_next_byte (m_next_byte),
        .m_data_out  (m_data_out),
        .m_busy      (m_busy),
        .m_done      (m_done),
        .m_ack_error (m_ack_error)
    );

    initial clk_400 = 1'b0;
    always #5 clk_400 = ~clk_400;

    // ------------------------------------------------------------------
    // Behavioural master + subordinates at 0x01 and 0x22. Acts on the
    // falling edge so the arbiter sees its outputs at the next rising edge.
    // done stays high as a level until the next start.
    // ------------------------------------------------------------------
    logic [7:0] smem [0:127];
    bit         mst_busy_en;
    int         mst_cnt;
    logic       mst_rw;
    logic [6:0] mst_addr;
    logic [7:0] mst_wd;

    initial begin
        for (int i = 0; i < 128; i++) smem[i] = 8'h00;
        m_busy = 1'b0; m_done = 1'b0; m_data_out = 8'h00; m_ack_error = 1'b0;
        mst_cnt = 0; mst_rw = 1'b0; mst_addr = '0; mst_wd = '0;
        forever begin
            @(negedge clk_400);
            if (rst) begin
                m_busy = 1'b0; m_done = 1'b0; m_data_out = 8'h00; m_ack_error = 1'b0;
                mst_cnt = 0;
            end else if (mst_cnt > 0) begin
                mst_cnt--;
                if (mst_cnt == 0) begin
                    m_busy = 1'b0;
                    m_done = 1'b1;
                    if (mst_addr == 7'h01 || mst_addr == 7'h22) begin
                        m_ack_error = 1'b0;
                        if (mst_rw) m_data_out = smem[mst_addr];
                        else begin
                            smem[mst_addr] = mst_wd;
                            m_data_out = 8'h99;
                        end
                    end else begin
                        m_ack_error = 1'b1;
                        m_data_out  = 8'hEE;
                    end
                end
            end else if (m_start_txn && mst_busy_en) begin
                m_busy = 1'b1; m_done = 1'b0; m_ack_error = 1'b0;
                mst_cnt = MST_LAT;
                mst_rw = m_rw; mst_addr = m_sub_addr; mst_wd = m_data_in;
            end
        end
    end

    // ------------------------------------------------------------------
    // Checking helpers
    // ------------------------------------------------------------------
    int n_cmp;
    int n_err;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    typedef struct {
        int         idx;
        bit         rw;
        logic [6:0] addr;
        logic [7:0] wdata;
        logic [7:0] exp_rdata;
        logic [1:0] exp_err;
    } vec_t;

    typedef struct {
        logic [7:0]         rd;
        logic [1:0]         er;
        logic [NUM_REQ-1:0] vld;
        logic [NUM_REQ-1:0] gnt;
        logic               c_rw;
        logic [6:0]         c_addr;
        logic [7:0]         c_wd;
        int                 lat;
        int                 starts;
        int                 rcyc;
        bit                 tmo;
    } res_t;

    // Caller must be at #1 after a rising edge with the arbiter in IDLE.
    task automatic run_txn(input int idx, input bit rw, input logic [6:0] a,
                           input logic [7:0] d, output res_t r);
        int cyc;
        r = '{rd: 8'h00, er: 2'b00, vld: '0, gnt: '0, c_rw: 1'b0, c_addr: '0,
              c_wd: '0, lat: -1, starts: 0, rcyc: -1, tmo: 1'b1};
        req_rw[idx] = rw;
        req_addr[7*idx +: 7] = a;
        req_wdata[8*idx +: 8] = d;
        req[idx] = 1'b1;
        cyc = 0;
        for (int c = 0; c < 400; c++) begin
            @(posedge clk_400); #1;
            cyc++;
            if (m_start_txn) begin
                r.starts++;
                if (r.lat < 0) begin
                    r.lat = cyc; r.gnt = grant;
                    r.c_rw = m_rw; r.c_addr = m_sub_addr; r.c_wd = m_data_in;
                end
            end
            if (rsp_valid != '0) begin
                r.rd = rsp_rdata; r.er = rsp_err; r.vld = rsp_valid;
                r.rcyc = cyc; r.tmo = 1'b0;
                break;
            end
        end
        req[idx] = 1'b0;
    endtask

    task automatic idle_chk(input string name);
        @(posedge clk_400); #1;
        chk(name, {grant, rsp_valid, m_start_txn, m_rw, m_sub_addr, m_data_in}, 32'h0);
    endtask

    vec_t       vecs [8];
    res_t       res;
    int         order [$];
    int         cnt0, cnt1, got, seen_rsp, seen_start;
    bit         onehot_ok, hit;
    int         exp_ord [4];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_cmp = 0; n_err = 0;
        mst_busy_en = 1'b1;
        req = '0; req_rw = '0; req_addr = '0; req_wdata = '0;
        rst = 1'b1;
        exp_ord = '{0, 1, 0, 1};

        //            idx rw addr   wdata  rdata  err
        vecs[0] = '{0, 1'b0, 7'h01, 8'hAB, 8'h00, 2'b00};
        vecs[1] = '{1, 1'b1, 7'h01, 8'h00, 8'hAB, 2'b00};
        vecs[2] = '{0, 1'b0, 7'h01, 8'hC3, 8'h00, 2'b00};
        vecs[3] = '{1, 1'b1, 7'h01, 8'h00, 8'hC3, 2'b00};
        vecs[4] = '{0, 1'b1, 7'h55, 8'h00, 8'h00, 2'b01};
        vecs[5] = '{1, 1'b0, 7'h55, 8'h77, 8'h00, 2'b01};
        vecs[6] = '{1, 1'b0, 7'h22, 8'h5A, 8'h00, 2'b00};
        vecs[7] = '{0, 1'b1, 7'h22, 8'h00, 8'h5A, 2'b00};

        repeat (3) @(posedge clk_400);
        #1;
        chk("reset outputs",
            {grant, rsp_valid, rsp_rdata, rsp_err, m_start_txn, m_rw, m_sub_addr, m_data_in, m_next_byte},
            32'h0);
        rst = 1'b0;
        @(posedge clk_400); #1;

        // ---------------- table-driven single transactions ----------------
        for (int i = 0; i < 8; i++) begin
            run_txn(vecs[i].idx, vecs[i].rw, vecs[i].addr, vecs[i].wdata, res);
            chk($sformatf("v%0d done", i), 32'(res.tmo), 32'd0);
            chk($sformatf("v%0d rsp_valid", i), 32'(res.vld), 32'(1 << vecs[i].idx));
            chk($sformatf("v%0d rsp_rdata", i), 32'(res.rd), 32'(vecs[i].exp_rdata));
            chk($sformatf("v%0d rsp_err", i), 32'(res.er), 32'(vecs[i].exp_err));
            chk($sformatf("v%0d start latency", i), 32'(res.lat), 32'd2);
            chk($sformatf("v%0d start pulses", i), 32'(res.starts), 32'd1);
            chk($sformatf("v%0d rsp cycle", i), 32'(res.rcyc), 32'(3 + MST_LAT));
            chk($sformatf("v%0d grant", i), 32'(res.gnt), 32'(1 << vecs[i].idx));
            chk($sformatf("v%0d cmd", i), {16'h0, res.c_rw, res.c_addr, res.c_wd},
                {16'h0, vecs[i].rw, vecs[i].addr, vecs[i].wdata});
            if (!vecs[i].rw && vecs[i].exp_err == 2'b00)
                chk($sformatf("v%0d sub mem", i), 32'(smem[vecs[i].addr]), 32'(vecs[i].wdata));
            idle_chk($sformatf("v%0d idle", i));
        end

        // ---------------- simultaneous requests from reset ----------------
        rst = 1'b1;
        @(posedge clk_400); #1;
        rst = 1'b0;
        req_rw = 2'b11;
        req_addr = {7'h01, 7'h01};
        req = 2'b11;
        order.delete();
        cnt0 = 0; cnt1 = 0; onehot_ok = 1'b1;
        for (int c = 0; c < 300; c++) begin
            @(posedge clk_400); #1;
            if (!$onehot0(grant)) onehot_ok = 1'b0;
            if (rsp_valid == 2'b01) begin
                order.push_back(0); cnt0++;
                if (cnt0 == 2) req[0] = 1'b0;
            end else if (rsp_valid == 2'b10) begin
                order.push_back(1); cnt1++;
                if (cnt1 == 2) req[1] = 1'b0;
            end else if (rsp_valid != 2'b00) begin
                order.push_back(9);
            end
            if (order.size() >= 4) break;
        end
        req = 2'b00;
        chk("rr count", 32'(order.size()), 32'd4);
        for (int i = 0; i < 4; i++) begin
            got = (i < order.size()) ? order[i] : 99;
            chk($sformatf("rr order %0d", i), 32'(got), 32'(exp_ord[i]));
        end
        chk("rr grant onehot", 32'(onehot_ok), 32'd1);
        idle_chk("rr idle");

        // ---------------- req dropped / changed while granted ----------------
        req_rw[1] = 1'b0; req_addr[13:7] = 7'h22; req_wdata[15:8] = 8'h3C;
        req[1] = 1'b1;
        hit = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk_400); #1;
            if (grant == 2'b10) begin hit = 1'b1; break; end
        end
        chk("drop granted", 32'(hit), 32'd1);
        req[1] = 1'b0; req_addr[13:7] = 7'h55; req_wdata[15:8] = 8'h00; req_rw[1] = 1'b1;
        @(posedge clk_400); #1;
        chk("drop cmd held", {17'h0, m_rw, m_sub_addr, m_data_in}, {17'h0, 1'b0, 7'h22, 8'h3C});
        hit = 1'b0;
        for (int c = 0; c < 100; c++) begin
            @(posedge clk_400); #1;
            if (rsp_valid != '0) begin
                hit = 1'b1;
                chk("drop rsp_valid", 32'(rsp_valid), 32'h2);
                chk("drop rsp_err", 32'(rsp_err), 32'h0);
                break;
            end
        end
        chk("drop rsp seen", 32'(hit), 32'd1);
        chk("drop sub mem", 32'(smem[7'h22]), 32'h3C);
        idle_chk("drop idle");

        // ---------------- busy never rises -> timeout ----------------
        mst_busy_en = 1'b0;
        run_txn(0, 1'b0, 7'h01, 8'h42, res);
        chk("tmo done", 32'(res.tmo), 32'd0);
        chk("tmo rsp_valid", 32'(res.vld), 32'h1);
        chk("tmo rsp_err", 32'(res.er), 32'h2);
        chk("tmo rsp_rdata", 32'(res.rd), 32'h0);
        chk("tmo rsp cycle", 32'(res.rcyc), 32'(2 + TIMEOUT_CYC));
        idle_chk("tmo idle");
        mst_busy_en = 1'b1;
        run_txn(1, 1'b1, 7'h01, 8'h00, res);
        chk("post tmo rsp_valid", 32'(res.vld), 32'h2);
        chk("post tmo rdata", 32'(res.rd), 32'hC3);
        chk("post tmo err", 32'(res.er), 32'h0);
        idle_chk("post tmo idle");

        // ---------------- reset during RUN ----------------
        req_rw[0] = 1'b0; req_addr[6:0] = 7'h01; req_wdata[7:0] = 8'h11;
        req[0] = 1'b1;
        hit = 1'b0;
        for (int c = 0; c < 50; c++) begin
            @(posedge clk_400); #1;
            if (m_busy && grant == 2'b01) begin hit = 1'b1; break; end
        end
        chk("rst reached run", 32'(hit), 32'd1);
        rst = 1'b1;
        req[0] = 1'b0;
        #1;
        chk("rst async clear", {grant, rsp_valid, m_start_txn, m_rw, m_sub_addr, m_data_in}, 32'h0);
        @(posedge clk_400); #1;
        rst = 1'b0;
        seen_rsp = 0; seen_start = 0;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk_400); #1;
            if (rsp_valid != '0) seen_rsp++;
            if (m_start_txn) seen_start++;
        end
        chk("rst no rsp", 32'(seen_rsp), 32'd0);
        chk("rst no start", 32'(seen_start), 32'd0);
        run_txn(0, 1'b0, 7'h01, 8'h66, res);
        chk("post rst rsp_valid", 32'(res.vld), 32'h1);
        chk("post rst err", 32'(res.er), 32'h0);
        chk("post rst latency", 32'(res.lat), 32'd2);
        chk("post rst sub mem", 32'(smem[7'h01]), 32'h66);
        idle_chk("post rst idle");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
